// File: rtl/devision_pkg.sv
`default_nettype none
// ============================================================================
// Module   : devision_pkg
// Brief    : State encoding and default width shared by the division
//            controller and its datapath.
// Revision : 1.0
// ============================================================================
package devision_pkg;

    localparam int DEFAULT_WIDTH = 5;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t LOAD_A = 3'd1;
    localparam state_t LOAD_B = 3'd2;
    localparam state_t CHECK  = 3'd3;
    localparam state_t SUB    = 3'd4;
    localparam state_t WB     = 3'd5;
    localparam state_t DONE   = 3'd6;
    localparam state_t ERR    = 3'd7;

endpackage
`default_nettype wire

// File: rtl/devision_datapath.sv
`default_nettype none
// ============================================================================
// Module   : devision_datapath
// Brief    : Repeated-subtraction datapath: registered bus mux, A/B
//            registers, quotient counter P and comparator.
// Revision : 1.0
// ============================================================================
module devision_datapath
    import devision_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             lda,
    input  logic             ldb,
    input  logic             clrp,
    input  logic             incp,
    input  logic             selin,
    output logic             lt,
    output logic             gt,
    output logic             eq,
    output logic [WIDTH-1:0] a_val,
    output logic [WIDTH-1:0] b_val,
    output logic [WIDTH-1:0] p_val
);

    logic [WIDTH-1:0] r_bus;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] w_diff;

    assign w_diff = r_a - r_b;

    // The bus register captures every cycle; loads consume last cycle's value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_p   <= '0;
        end else begin
            r_bus <= selin ? w_diff : data_in;
            if (lda)
                r_a <= r_bus;
            if (ldb)
                r_b <= r_bus;
            if (clrp)
                r_p <= '0;
            else if (incp)
                r_p <= r_p + 1'b1;
        end
    end

    assign lt    = (r_a <  r_b);
    assign gt    = (r_a >  r_b);
    assign eq    = (r_a == r_b);
    assign a_val = r_a;
    assign b_val = r_b;
    assign p_val = r_p;

endmodule
`default_nettype wire

// File: rtl/devision_controller.sv
`default_nettype none
// ============================================================================
// Module   : devision_controller
// Brief    : Moore FSM sequencing the repeated-subtraction divider; flags
//            divide-by-zero and pulses done on completion.
// Revision : 1.0
// ============================================================================
module devision_controller
    import devision_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             lt,
    input  logic             gt,
    input  logic             eq,
    output logic             lda,
    output logic             ldb,
    output logic             clrp,
    output logic             incp,
    output logic             selin,
    output logic             busy,
    output logic             done,
    output logic             dz
);

    state_t r_state;
    state_t w_next;
    logic   r_zero_q;
    logic   w_unused_flags;

    // Only lt steers the loop; gt/eq are carried for interface completeness.
    assign w_unused_flags = gt | eq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_zero_q <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == LOAD_A)
                r_zero_q <= (data_in == '0);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? LOAD_A : IDLE;
            LOAD_A:  w_next = LOAD_B;
            LOAD_B:  w_next = r_zero_q ? ERR : CHECK;
            CHECK:   w_next = lt ? DONE : SUB;
            SUB:     w_next = WB;
            WB:      w_next = CHECK;
            DONE:    w_next = IDLE;
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // selin stays high through SUB so the bus still holds A-B when WB loads A.
    always_comb begin
        lda   = 1'b0;
        ldb   = 1'b0;
        clrp  = 1'b0;
        incp  = 1'b0;
        selin = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        dz    = 1'b0;
        case (r_state)
            LOAD_A: begin
                lda  = 1'b1;
                busy = 1'b1;
            end
            LOAD_B: begin
                ldb  = 1'b1;
                clrp = 1'b1;
                busy = 1'b1;
            end
            CHECK: begin
                selin = 1'b1;
                busy  = 1'b1;
            end
            SUB: begin
                incp  = 1'b1;
                selin = 1'b1;
                busy  = 1'b1;
            end
            WB: begin
                lda  = 1'b1;
                busy = 1'b1;
            end
            DONE: done = 1'b1;
            ERR: begin
                done = 1'b1;
                dz   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_devision_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_devision_controller
// Brief    : Controller plus datapath exercised with directed and random
//            divisions against an arithmetic reference.
// Revision : 1.0
// ============================================================================
module tb_devision_controller;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] data_in;
    logic         lt, gt, eq;
    logic         lda, ldb, clrp, incp, selin, busy, done, dz;
    logic [W-1:0] a_val, b_val, p_val;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    devision_controller #(.WIDTH(W)) u_ctrl (
        .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
        .lt(lt), .gt(gt), .eq(eq),
        .lda(lda), .ldb(ldb), .clrp(clrp), .incp(incp), .selin(selin),
        .busy(busy), .done(done), .dz(dz)
    );

    devision_datapath #(.WIDTH(W)) u_dp (
        .clk(clk), .rst_n(rst_n), .data_in(data_in),
        .lda(lda), .ldb(ldb), .clrp(clrp), .incp(incp), .selin(selin),
        .lt(lt), .gt(gt), .eq(eq),
        .a_val(a_val), .b_val(b_val), .p_val(p_val)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One division; expectations come from integer divide/modulo and the
    // 4+3q (or 3 for zero divisor) latency rule.
    task automatic run_div(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input bit noisy);
        int  cyc, incs, lat, exp_q, exp_r, exp_lat;
        bit  seen;
        exp_q   = (dvs == 0) ? 0 : int'(dvd) / int'(dvs);
        exp_r   = (dvs == 0) ? 0 : int'(dvd) % int'(dvs);
        exp_lat = (dvs == 0) ? 3 : 4 + 3 * exp_q;

        @(negedge clk);
        check("idle_before_start", {31'd0, done | busy}, 0);
        start   = 1'b1;
        data_in = dvd;
        @(negedge clk);
        start   = 1'b0;
        data_in = dvs;
        cyc     = 1;
        check("busy_after_start", {31'd0, busy}, 1);

        incs = 0;
        seen = 1'b0;
        lat  = -1;
        while (cyc < 200 && !seen) begin
            if (incp)
                incs++;
            if (done) begin
                seen = 1'b1;
                lat  = cyc;
                check("dz_flag", {31'd0, dz}, (dvs == 0) ? 1 : 0);
                check("busy_at_done", {31'd0, busy}, 0);
                check("quotient", {27'd0, p_val}, exp_q);
                if (dvs != 0)
                    check("remainder", {27'd0, a_val}, exp_r);
                if (noisy)
                    start = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
                if (noisy) begin
                    start   = 1'($urandom_range(0, 1));
                    data_in = W'($urandom);
                end
            end
        end
        check("done_seen", {31'd0, seen}, 1);
        check("latency", lat, exp_lat);
        check("incp_count", incs, exp_q);
    endtask

    initial begin
        int guard;
        int dones;
        logic [W-1:0] rd, rs;

        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {24'd0, lda, ldb, clrp, incp, selin, busy, done, dz}, 0);
        rst_n = 1'b1;

        run_div(5'd13, 5'd4, 1'b1);
        run_div(5'd9,  5'd3, 1'b0);
        run_div(5'd3,  5'd5, 1'b0);
        run_div(5'd7,  5'd0, 1'b1);
        run_div(5'd31, 5'd1, 1'b0);
        run_div(5'd10, 5'd5, 1'b0);
        run_div(5'd0,  5'd7, 1'b0);

        // Abandon 20 / 3 during SUB with an asynchronous reset.
        @(negedge clk);
        start   = 1'b1;
        data_in = 5'd20;
        @(negedge clk);
        start   = 1'b0;
        data_in = 5'd3;
        guard   = 0;
        while (!incp && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("reached_sub", {31'd0, incp}, 1);
        #1 rst_n = 1'b0;
        #1 check("async_reset_outputs",
                 {24'd0, lda, ldb, clrp, incp, selin, busy, done, dz}, 0);
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) dones++;
        end
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("no_done_after_reset", dones, 0);

        run_div(5'd6, 5'd2, 1'b0);

        repeat (20) begin
            rd = W'($urandom);
            rs = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            run_div(rd, rs, 1'b1);
        end

        @(negedge clk);
        start = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/devision_controller.md
Name: devision_controller

Overview:
- Moore FSM that sequences the repeated-subtraction division datapath (registers A/B, quotient counter P, subtractor, comparator, registered bus mux).
- Accepts a start/dividend/divisor handshake and drives lda, ldb, clrp, incp and selin.
- Uses comparator lt to end the loop, flags divide-by-zero, and signals completion with done.
- Sits beside the datapath inside the divider top level.

Parameters:
- WIDTH, 5, operand, bus and quotient width; must match the datapath.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- data_in  input  WIDTH  same bus as datapath data_in; controller inspects it only for the zero-divisor check.
- lt  input  1  comparator: remainder < divisor.
- gt  input  1  comparator flag; not used for decisions.
- eq  input  1  comparator flag; not used for decisions.
- lda  output  1  load A from bus.
- ldb  output  1  load B from bus.
- clrp  output  1  clear quotient counter P.
- incp  output  1  increment P.
- selin  output  1  bus mux select: 0 = data_in, 1 = subtractor out.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle completion pulse.
- dz  output  1  divide-by-zero, pulses together with done.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset: state = IDLE; all outputs 0 immediately on rst_n low, independent of clk. Reset mid-operation abandons the division; no done pulse is produced. Datapath register contents after reset are don't-care.
- Output decoding: all outputs are decoded from the state register only, so there is no input-to-output combinational path.
- Bus timing: the bus mux is registered, so the bus carries the value selected by selin one cycle earlier. The controller sets selin one state ahead of the matching load.

State sequence:
- IDLE: all outputs 0. If start=1, the dividend must be on data_in this cycle; it is captured into the bus register (selin=0). Next state LOAD_A.
- LOAD_A: lda=1, busy=1, selin=0. A takes the dividend; the divisor must be on data_in this cycle and is captured into the bus. zero_q <= (data_in == 0). Next state LOAD_B.
- LOAD_B: ldb=1, clrp=1, busy=1. Next state ERR if zero_q=1, else CHECK.
- CHECK: busy=1, selin=1, so the bus captures A-B. Next state DONE if lt=1, else SUB. gt and eq are not decision inputs; any state with lt=0 (including eq=1) continues.
- SUB: incp=1, busy=1. Next state WB.
- WB: lda=1, busy=1, so A takes the new remainder. Next state CHECK.
- DONE: done=1, busy=0. P holds the quotient and A holds the remainder. Next state IDLE.
- ERR: done=1, dz=1, busy=0. P = 0. Next state IDLE.

Timing and boundary conditions:
- Latency: start accepted at cycle 0. done at cycle 4+3q (q = quotient); divide-by-zero done at cycle 3.
- start outside IDLE is ignored, including in DONE and ERR. The earliest re-accept is the cycle after done.
- Quotient bound: q <= 2^WIDTH-1, so P never wraps and no timeout is needed.
- Dividend 0 with nonzero divisor: lt=1 at the first CHECK, so q=0 and remainder 0.
- zero_q is an internal register; reset value 0.

Decomposition:
- devision_pkg: state encoding localparams (IDLE, LOAD_A, LOAD_B, CHECK, SUB, WB, DONE, ERR; 3-bit binary) and default WIDTH.
- No sub-module: one sequential block for state and zero_q, one combinational block for next state and output decode.
- The bench top instantiates devision_datapath together with this controller.

Test Plan:
- 13 / 4: start, then data_in 13 followed by 4 -> incp pulses 3 times; done at cycle 13 with dz=0; P=3; A=1.
- 3 / 5: -> no incp; done at cycle 4; P=0; A=3.
- 7 / 0: -> dz=1 and done=1 at cycle 3; P=0; no incp ever.
- 31 / 1: -> 31 incp pulses; done at cycle 97; P=31 with no wrap; A=0. Also 10 / 5 (eq path) -> P=2, A=0.
- Start pulsed during busy and on the done cycle -> ignored. Back-to-back 9 / 3 started the cycle after done -> P=3.
- rst_n asserted low during SUB of 20 / 3 -> outputs 0 asynchronously and no done pulse. After release, a new 6 / 2 completes with P=3.
